// File: rtl/monsopc_sysid_pkg.sv
// monsopc_sysid_pkg: word map, CONTROL bit indices and CAPS layout for the sysid slave
package monsopc_sysid_pkg;
  localparam logic [3:0] A_ID      = 4'd0;
  localparam logic [3:0] A_TS      = 4'd1;
  localparam logic [3:0] A_UP_LO   = 4'd2;
  localparam logic [3:0] A_UP_HI   = 4'd3;
  localparam logic [3:0] A_SCRATCH = 4'd4;
  localparam logic [3:0] A_CAPS    = 4'd5;
  localparam logic [3:0] A_CONTROL = 4'd6;
  localparam int CTRL_CLEAR  = 0;
  localparam int CTRL_FREEZE = 1;
  typedef struct packed {
    logic [15:0] rsvd;
    logic [7:0]  n_user;
    logic [7:0]  read_latency;
  } caps_t;
  function automatic logic [31:0] be_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] be);
    for (int i = 0; i < 4; i++)
      if (be[i]) old_v[8*i+:8] = new_v[8*i+:8];
    return old_v;
  endfunction
endpackage

// File: rtl/monsopc_sysid_rdpipe.sv
// monsopc_sysid_rdpipe: valid+data shift register delaying read responses by DEPTH cycles
module monsopc_sysid_rdpipe #(
  parameter int DEPTH = 1,
  parameter int W     = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  logic [DEPTH-1:0] v;
  logic [W-1:0]     d [DEPTH];
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) d[i] <= '0;
    end else begin
      v[0] <= in_valid;
      d[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        v[i] <= v[i-1];
        d[i] <= d[i-1];
      end
    end
  end
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
endmodule

// File: rtl/monsopc_sysid_ext.sv
// monsopc_sysid_ext: sysid/housekeeping register file with uptime counter and pipelined reads
module monsopc_sysid_ext
  import monsopc_sysid_pkg::*;
#(
  parameter logic [31:0] ID_VALUE     = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP    = 32'd0,
  parameter logic [31:0] SCRATCH_INIT = 32'h0000_0000,
  parameter int          N_USER       = 4,
  parameter int          READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);
  if (N_USER < 0 || N_USER > 8 || READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_params
    $fatal(1, "monsopc_sysid_ext: N_USER must be 0..8 and READ_LATENCY 1..3");
  end
  logic [63:0] uptime;
  logic [31:0] shadow, scratch, rd_mux, ctrl_rd;
  logic [31:0] user [8];
  logic        freeze, ctrl_wr, clear;
  caps_t       caps;
  assign ctrl_wr = write && address == A_CONTROL && byteenable[0];
  assign clear   = ctrl_wr && writedata[CTRL_CLEAR];
  assign caps    = '{rsvd: 16'h0, n_user: 8'(N_USER), read_latency: 8'(READ_LATENCY)};
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      uptime  <= '0;
      shadow  <= '0;
      scratch <= SCRATCH_INIT;
      freeze  <= 1'b0;
    end else begin
      if (clear) uptime <= '0;
      else if (!freeze) uptime <= uptime + 64'd1;
      if (read && address == A_UP_LO) shadow <= uptime[63:32];
      if (write && address == A_SCRATCH) scratch <= be_merge(scratch, writedata, byteenable);
      if (ctrl_wr) freeze <= writedata[CTRL_FREEZE];
    end
  end
  // Unimplemented user slots never load, so they hold 0 and read as unmapped
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 8; k++) user[k] <= '0;
    end else begin
      for (int k = 0; k < 8; k++)
        if (k < N_USER && write && address == {1'b1, 3'(k)})
          user[k] <= be_merge(user[k], writedata, byteenable);
    end
  end
  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CTRL_FREEZE] = freeze;
    rd_mux = '0;
    if (address[3]) rd_mux = user[address[2:0]];
    else
      case (address)
        A_ID:      rd_mux = ID_VALUE;
        A_TS:      rd_mux = TIMESTAMP;
        A_UP_LO:   rd_mux = uptime[31:0];
        A_UP_HI:   rd_mux = shadow;
        A_SCRATCH: rd_mux = scratch;
        A_CAPS:    rd_mux = caps;
        A_CONTROL: rd_mux = ctrl_rd;
        default:   rd_mux = '0;
      endcase
  end
  monsopc_sysid_rdpipe #(.DEPTH(READ_LATENCY), .W(32)) u_rdpipe (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (read),
    .in_data  (read ? rd_mux : 32'h0),
    .out_valid(readdatavalid),
    .out_data (readdata)
  );
endmodule

// File: tb/tb_monsopc_sysid_ext.sv
// tb_monsopc_sysid_ext: directed checks of the sysid slave at read latency 2 and 3
module tb_monsopc_sysid_ext;
  localparam logic [31:0] ID = 32'h5FA5_1A18;
  localparam logic [31:0] TS = 32'h6543_2100;
  logic        clock = 1'b0, reset_n = 1'b0, read = 1'b0, write = 1'b0;
  logic [3:0]  address = '0, byteenable = '0;
  logic [31:0] writedata = '0;
  logic [31:0] rdata, rdata3;
  logic        rvalid, rvalid3;
  logic [32:0] ra, rb;
  int n_chk = 0, n_fail = 0;
  always #5 clock = ~clock;
  monsopc_sysid_ext #(.ID_VALUE(ID), .TIMESTAMP(TS), .SCRATCH_INIT(32'h0), .N_USER(4),
                      .READ_LATENCY(2)) dut (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .readdata(rdata), .readdatavalid(rvalid));
  monsopc_sysid_ext #(.ID_VALUE(ID), .TIMESTAMP(TS), .SCRATCH_INIT(32'h0), .N_USER(4),
                      .READ_LATENCY(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .readdata(rdata3), .readdatavalid(rvalid3));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    write = 1'b1; address = a; writedata = d; byteenable = be;
    @(negedge clock);
    write = 1'b0; byteenable = '0;
  endtask
  task automatic rd(input logic [3:0] a, output logic [32:0] r);
    read = 1'b1; address = a;
    @(negedge clock);
    read = 1'b0;
    @(negedge clock);
    r = {rvalid, rdata};
  endtask
  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [32:0] r;
    rd(a, r);
    check(tag, 64'(r), {31'h0, 1'b1, exp});
  endtask
  initial begin
    repeat (3) @(negedge clock);
    check("rst_out2", {31'h0, rvalid, rdata}, 64'h0);
    check("rst_out3", {31'h0, rvalid3, rdata3}, 64'h0);
    reset_n = 1'b1;
    @(negedge clock);
    // back-to-back reads: latency-2 and latency-3 responses overlap on the same bus
    read = 1'b1; address = 4'd0;
    @(negedge clock);
    check("b2b_idle2", {31'h0, rvalid, rdata}, 64'h0);
    check("b2b_idle3", {31'h0, rvalid3, rdata3}, 64'h0);
    address = 4'd1;
    @(negedge clock);
    check("b2b_id2", {31'h0, rvalid, rdata}, {32'h1, ID});
    check("b2b_idle3b", {31'h0, rvalid3, rdata3}, 64'h0);
    address = 4'd5;
    @(negedge clock);
    read = 1'b0;
    check("b2b_ts2", {31'h0, rvalid, rdata}, {32'h1, TS});
    check("b2b_id3", {31'h0, rvalid3, rdata3}, {32'h1, ID});
    @(negedge clock);
    check("b2b_caps2", {31'h0, rvalid, rdata}, {32'h1, 32'h0000_0402});
    check("b2b_ts3", {31'h0, rvalid3, rdata3}, {32'h1, TS});
    @(negedge clock);
    check("b2b_end2", {31'h0, rvalid, rdata}, 64'h0);
    check("b2b_caps3", {31'h0, rvalid3, rdata3}, {32'h1, 32'h0000_0403});
    rd_chk("rst_scratch", 4'd4, 32'h0);
    rd_chk("rst_hi", 4'd3, 32'h0);
    rd_chk("rst_ctrl", 4'd6, 32'h0);
    rd_chk("rst_user0", 4'd8, 32'h0);
    wr(4'd4, 32'hDEAD_BEEF, 4'b0101);
    rd_chk("scratch_be", 4'd4, 32'h00AD_00EF);
    wr(4'd12, 32'h1234_5678, 4'hF);
    rd_chk("user_unmapped", 4'd12, 32'h0);
    wr(4'd9, 32'hA5A5_0001, 4'hF);
    rd_chk("user1", 4'd9, 32'hA5A5_0001);
    wr(4'd11, 32'h1234_5678, 4'b1100);
    rd_chk("user3_be", 4'd11, 32'h1234_0000);
    rd_chk("unmapped7", 4'd7, 32'h0);
    wr(4'd0, 32'hFFFF_FFFF, 4'hF);
    rd_chk("id_ro", 4'd0, ID);
    wr(4'd6, 32'h2, 4'hF);
    rd(4'd2, ra);
    repeat (10) @(negedge clock);
    rd(4'd2, rb);
    check("frz_valid", {63'h0, ra[32]}, 64'h1);
    check("frz_equal", 64'(rb), 64'(ra));
    wr(4'd6, 32'h3, 4'hF);
    rd_chk("clr_frz_lo", 4'd2, 32'h0);
    repeat (10) @(negedge clock);
    rd_chk("clr_frz_lo2", 4'd2, 32'h0);
    rd_chk("ctrl_frz", 4'd6, 32'h2);
    wr(4'd6, 32'h0, 4'hF);
    rd_chk("run_lo0", 4'd2, 32'h0);
    rd_chk("run_lo2", 4'd2, 32'h2);
    wr(4'd6, 32'h1, 4'hF);
    rd_chk("clr_run_lo0", 4'd2, 32'h0);
    rd_chk("clr_run_lo2", 4'd2, 32'h2);
    rd_chk("ctrl_run", 4'd6, 32'h0);
    // preload the frozen counter just below the 32-bit carry, then let it run
    wr(4'd6, 32'h2, 4'hF);
    force dut.uptime = 64'h0000_0000_FFFF_FFFE;
    #1;
    release dut.uptime;
    wr(4'd6, 32'h0, 4'hF);
    rd_chk("wrap_lo", 4'd2, 32'hFFFF_FFFE);
    repeat (2) @(negedge clock);
    rd_chk("wrap_hi", 4'd3, 32'h0);
    rd_chk("wrap_lo2", 4'd2, 32'h4);
    rd_chk("wrap_hi2", 4'd3, 32'h1);
    wr(4'd4, 32'h1, 4'hF);
    read = 1'b1; write = 1'b1; address = 4'd4; writedata = 32'h2; byteenable = 4'hF;
    @(negedge clock);
    read = 1'b0; write = 1'b0; byteenable = '0;
    @(negedge clock);
    check("rw_old", {31'h0, rvalid, rdata}, {32'h1, 32'h1});
    rd_chk("rw_new", 4'd4, 32'h2);
    read = 1'b1; address = 4'd0;
    @(negedge clock);
    address = 4'd1;
    @(negedge clock);
    address = 4'd5;
    @(posedge clock);
    #1 reset_n = 1'b0;
    read = 1'b0;
    @(negedge clock);
    check("rst_mid2", {31'h0, rvalid, rdata}, 64'h0);
    check("rst_mid3", {31'h0, rvalid3, rdata3}, 64'h0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("flush2", {31'h0, rvalid, rdata}, 64'h0);
      check("flush3", {31'h0, rvalid3, rdata3}, 64'h0);
    end
    rd_chk("post_scratch", 4'd4, 32'h0);
    rd_chk("post_user1", 4'd9, 32'h0);
    rd_chk("post_hi", 4'd3, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/monsopc_sysid_ext.md
# monsopc_sysid_ext

Parametrised system-identification and housekeeping slave on the SOPC Avalon-MM interconnect. It replaces the fixed two-word ID/timestamp slave with a register file. The file holds the ID, the build timestamp, a 64-bit uptime counter with atomic high-word snapshot, a scratch register, a capability word, a control register and up to eight software-writable user words. Read data is returned through a configurable-latency pipeline with `readdatavalid`, so the block can sit behind registered interconnect.

## Interface

Parameters:
- `ID_VALUE`, 32'h0000_0000: system ID returned at word 0.
- `TIMESTAMP`, 32'd0: build timestamp returned at word 1.
- `SCRATCH_INIT`, 32'h0000_0000: reset value of SCRATCH.
- `N_USER`, 4: number of implemented user words; legal range 0..8.
- `READ_LATENCY`, 1: cycles from accepted read to `readdatavalid`; legal range 1..3.

Ports:
- `clock`  in  1  single clock for all logic.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  4  word address.
- `read`  in  1  read strobe; one read is accepted per cycle.
- `write`  in  1  write strobe.
- `writedata`  in  32  write data.
- `byteenable`  in  4  byte lanes for writes.
- `readdata`  out  32  read data; valid only when `readdatavalid` is high.
- `readdatavalid`  out  1  one-cycle qualifier for `readdata`.

## Operation

Word map (reads of unmapped words return 0; writes to unmapped or RO words are ignored):
- 0 ID: RO, returns `ID_VALUE`.
- 1 TIMESTAMP: RO, returns `TIMESTAMP`.
- 2 UPTIME_LO: RO, returns `uptime[31:0]`. The same accepted read copies `uptime[63:32]` into a shadow register.
- 3 UPTIME_HI: RO, returns the shadow. A 2-then-3 read pair is therefore coherent.
- 4 SCRATCH: RW, byte-enabled.
- 5 CAPS: RO, returns {16'h0, N_USER[7:0], READ_LATENCY[7:0]}.
- 6 CONTROL: bit0 CLEAR is write-1, self-clearing and always reads 0. Bit1 FREEZE is RW. Bits 31:2 read 0.
- 8..8+N_USER-1 USER[k]: RW, byte-enabled, reset to 0. Words 8+N_USER..15 are unmapped.

Uptime counter:
- 64-bit, increments by 1 every clock unless FREEZE=1.
- Wraps from 2^64-1 to 0 with no flag.
- A write of CLEAR=1 sets it to 0 on the following edge. CLEAR takes priority over increment, and clearing works while frozen.

Simultaneous `read` and `write`:
- The write takes effect on the edge.
- The read returns the value before that write.

## Timing

- Reset values: `readdata`=0, `readdatavalid`=0, uptime=0, shadow=0, SCRATCH=`SCRATCH_INIT`, FREEZE=0, all USER words 0.
- A read is accepted in cycle N, and its data is sampled from register state at the end of cycle N.
- `readdatavalid`=1 with that data in cycle N+READ_LATENCY, high for exactly one cycle.
- Back-to-back reads produce back-to-back valid cycles, in order, with no bubbles.
- `readdata` is 0 whenever `readdatavalid`=0.
- Writes have no response. Register state updates on the edge ending the write cycle.
- The uptime value returned by a read is the counter value in the accept cycle N.
- Reset asserted mid-pipeline flushes all in-flight reads: no `readdatavalid` is emitted for them after reset releases.
- No wait states: the block never stalls.

## Structure

- Package `monsopc_sysid_pkg` holds the word-address constants, the CONTROL bit indices and the CAPS field layout.
- Sub-module `monsopc_sysid_rdpipe`, parametrised by depth READ_LATENCY, is a valid+data shift register with asynchronous clear.
- The top level holds the register file, the uptime counter/shadow and the read mux.
- Elaboration-time check: N_USER outside 0..8 or READ_LATENCY outside 1..3 is a fatal error.

## Test plan

- Reset, then read words 0,1,5 back-to-back with ID_VALUE=32'h5FA5_1A18, READ_LATENCY=2, N_USER=4 -> `readdatavalid` in cycles N+2..N+4 with data 32'h5FA5_1A18, TIMESTAMP, 32'h0000_0402.
- Write SCRATCH=32'hDEAD_BEEF with byteenable=4'b0101 after reset (SCRATCH_INIT=0) -> read returns 32'h00AD_00EF. Write word 12 with N_USER=4 -> ignored, reads 0.
- Force the counter near the wrap point (FREEZE, CLEAR, free-run in a bench with the counter preloaded to 64'h0000_0000_FFFF_FFFE), read word 2 then 3 -> a coherent pair (LO=FFFF_FFFE, HI=0), not a torn one.
- Write CONTROL=2 (FREEZE), then read UPTIME_LO twice 10 cycles apart -> identical values. Write CONTROL=3 -> next read of LO returns 0. Read CONTROL -> 2.
- Write and read of SCRATCH in the same cycle (old value 1, new value 2) -> read returns 1, and a subsequent read returns 2.
- Issue 3 reads with READ_LATENCY=3, then assert reset_n=0 for 1 cycle one cycle later -> no `readdatavalid` ever, and all outputs are 0 during and after reset.
